// File: rtl/pilha_pkg.sv
// Shared definitions for the operand stack: command encodings, responder
// FSM states and the default word width / depth used by the control unit.
package pilha_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 16;

    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_PUSH    = 2'b01,
        OP_POP     = 2'b10,
        OP_REPLACE = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/pilha_resp_if.sv
// Command/response handshake between the control unit (master) and the
// operand-stack responder (slave).
interface pilha_resp_if #(
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/pilha_regfile.sv
// DEPTH x DATA_W storage for the operand stack: one synchronous write
// port and one asynchronous read port. Contents are intentionally not reset.
module pilha_regfile #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    // Write the addressed entry when enabled.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/pilha_resp.sv
// Operand-stack responder: accepts one PUSH/POP/REPLACE per 3-cycle
// transaction (IDLE -> EXEC -> RESP) and returns a one-cycle response beat.
// Optional: define PILHA_WATERMARK_EN to add the high_water output.
module pilha_resp
    import pilha_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    pilha_resp_if.slave       bus,
    input  logic              clr_err,
    output logic [DATA_W-1:0] tos,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              ovf,
    output logic              udf
`ifdef PILHA_WATERMARK_EN
    ,
    output logic [ADDR_W:0]   high_water
`endif
);
    state_t            state, state_nxt;
    op_t               op_q;
    logic [DATA_W-1:0] data_q;
    logic              accept;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] top_idx;
    logic [DATA_W-1:0] rd_data;

    logic [ADDR_W:0]   count_nxt;
    logic [DATA_W-1:0] rsp_data_nxt;
    logic              rsp_err_nxt;
    logic              set_ovf;
    logic              set_udf;

    assign empty   = (count == '0);
    assign full    = (count == (ADDR_W+1)'(DEPTH));
    assign top_idx = ADDR_W'(count - 1'b1);
    assign tos     = empty ? '0 : rd_data;
    assign accept  = (state == IDLE) && bus.cmd_valid && (bus.cmd_op != OP_NOP);

    pilha_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clock  (clock),
        .we     (we),
        .waddr  (waddr),
        .wdata  (data_q),
        .raddr  (top_idx),
        .rdata  (rd_data)
    );

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a NOP is consumed in IDLE without leaving it.
    always_comb begin
        state_nxt     = state;
        bus.cmd_ready = 1'b0;
        case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (accept) begin
                    state_nxt = EXEC;
                end
            end
            EXEC:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the command only on the accept edge.
    always_ff @(posedge clock) begin
        if (accept) begin
            op_q   <= op_t'(bus.cmd_op);
            data_q <= bus.cmd_data;
        end
    end

    // Stack access decode for the EXEC cycle, with explicit full/empty guards.
    always_comb begin
        we           = 1'b0;
        waddr        = top_idx;
        count_nxt    = count;
        rsp_data_nxt = '0;
        rsp_err_nxt  = 1'b0;
        set_ovf      = 1'b0;
        set_udf      = 1'b0;
        if (state == EXEC) begin
            case (op_q)
                OP_PUSH: begin
                    if (!full) begin
                        we           = 1'b1;
                        waddr        = count[ADDR_W-1:0];
                        count_nxt    = count + 1'b1;
                        rsp_data_nxt = data_q;
                    end else begin
                        rsp_err_nxt = 1'b1;
                        set_ovf     = 1'b1;
                    end
                end
                OP_POP: begin
                    if (!empty) begin
                        rsp_data_nxt = rd_data;
                        count_nxt    = count - 1'b1;
                    end else begin
                        rsp_err_nxt = 1'b1;
                        set_udf     = 1'b1;
                    end
                end
                OP_REPLACE: begin
                    if (!empty) begin
                        we           = 1'b1;
                        rsp_data_nxt = rd_data;
                    end else begin
                        rsp_err_nxt = 1'b1;
                        set_udf     = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Occupancy, response beat and sticky flags; a new error beats clr_err.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count        <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data <= '0;
            bus.rsp_err  <= 1'b0;
            ovf          <= 1'b0;
            udf          <= 1'b0;
        end else begin
            count         <= count_nxt;
            bus.rsp_valid <= (state == EXEC);
            if (state == EXEC) begin
                bus.rsp_data <= rsp_data_nxt;
                bus.rsp_err  <= rsp_err_nxt;
            end
            if (clr_err) begin
                ovf <= 1'b0;
                udf <= 1'b0;
            end
            if (set_ovf) begin
                ovf <= 1'b1;
            end
            if (set_udf) begin
                udf <= 1'b1;
            end
        end
    end

`ifdef PILHA_WATERMARK_EN
    // Highest occupancy seen since reset, tracked at the same edge as count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            high_water <= '0;
        end else if (count_nxt > high_water) begin
            high_water <= count_nxt;
        end
    end
`endif
endmodule
